// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register:
// operation select codes and burst FSM states.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-step shift/rotate datapath, shared by the
// burst engine and the free-running path.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       mode,
  input  logic             ser_lsb,
  input  logic             ser_msb,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    case (mode)
      MODE_SHL: nxt = {cur[WIDTH-2:0], ser_lsb};
      MODE_SHR: nxt = {ser_msb, cur[WIDTH-1:1]};
      MODE_ROL: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR: nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_ASR: nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:  nxt = cur;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with parallel
// load, serial ends and a counted burst-shift engine.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter  int               WIDTH     = 4,
  parameter  logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int               CW        = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       mode,
  input  logic             ser_lsb,
  input  logic             ser_msb,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] CMAX = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_nxt;
  logic [CW-1:0]    cnt_c;

  // The burst replays its latched mode, ignoring live inputs
  assign step_mode = (state_q == ST_RUN) ? mode_q : mode;
  assign cnt_c     = (count > CMAX) ? CMAX : count;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .cur     (out_q),
    .mode    (step_mode),
    .ser_lsb (ser_lsb),
    .ser_msb (ser_msb),
    .nxt     (step_nxt)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    out_d   = out_q;
    done_d  = 1'b0;
    if (load) begin
      out_d   = in;
      state_d = ST_IDLE;
      rem_d   = '0;
    end else if (state_q == ST_RUN) begin
      out_d = step_nxt;
      rem_d = rem_q - ONE;
      if (rem_q == ONE) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      if (cnt_c != '0) begin
        state_d = ST_RUN;
        rem_d   = cnt_c;
        mode_d  = mode;
      end else begin
        done_d = 1'b1;
      end
    end else begin
      out_d = step_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      mode_q  <= MODE_HOLD;
      out_q   <= RESET_VAL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and random checks of univ_shift_reg (WIDTH=4)
// against an arithmetic reference model.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] din;
  logic [2:0] mode;
  logic       ser_lsb;
  logic       ser_msb;
  logic       start;
  logic [2:0] count;
  logic [3:0] out;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  int m_out;
  int m_left;
  int m_mode;
  int m_done;

  univ_shift_reg #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .in      (din),
    .mode    (mode),
    .ser_lsb (ser_lsb),
    .ser_msb (ser_msb),
    .start   (start),
    .count   (count),
    .out     (out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic int ref_shift(int v, int m, int sl, int sm);
    case (m)
      1: return (v * 2 + sl) % 16;
      2: return v / 2 + sm * 8;
      3: return (v * 2) % 16 + v / 8;
      4: return v / 2 + (v % 2) * 8;
      5: return v / 2 + (v / 8) * 8;
      default: return v;
    endcase
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".out"}, int'(out), m_out);
    chk({tag, ".busy"}, int'(busy), int'(m_left > 0));
    chk({tag, ".done"}, int'(done), m_done);
  endtask

  // One clock: drive at negedge, advance model, check after posedge
  task automatic step(input logic ld, input int d, input int md,
                      input logic sl, input logic sm,
                      input logic st, input int cnt);
    int n;
    @(negedge clk);
    load = ld; din = 4'(d); mode = 3'(md);
    ser_lsb = sl; ser_msb = sm; start = st; count = 3'(cnt);
    m_done = 0;
    if (ld) begin
      m_out = d; m_left = 0;
    end else if (m_left > 0) begin
      m_out = ref_shift(m_out, m_mode, sl, sm);
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (st) begin
      n = (cnt > 4) ? 4 : cnt;
      if (n == 0) m_done = 1;
      else begin
        m_left = n; m_mode = md;
      end
    end else begin
      m_out = ref_shift(m_out, md, sl, sm);
    end
    @(posedge clk);
    #1;
    chk_all("step");
  endtask

  task automatic idle(input int md);
    step(1'b0, 0, md, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    m_out = 0; m_left = 0; m_done = 0;
    #1;
    chk_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 0; din = 0; mode = 0;
    ser_lsb = 0; ser_msb = 0; start = 0; count = 0;
    m_out = 0; m_left = 0; m_mode = 0; m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load, async reset mid-cycle, reload and hold
    step(1'b1, 4'b1001, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("load1001", int'(out), 4'b1001);
    async_reset();
    chk("rst_out0", int'(out), 0);
    step(1'b1, 4'b1001, 0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) idle(0);
    chk("hold", int'(out), 4'b1001);

    // Free-running single steps
    step(1'b0, 0, 1, 1'b1, 1'b0, 1'b0, 0);
    chk("shl", int'(out), 4'b0011);
    step(1'b0, 0, 2, 1'b1, 1'b0, 1'b0, 0);
    chk("shr", int'(out), 4'b0001);
    step(1'b1, 4'b1000, 0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 0, 5, 1'b1, 1'b1, 1'b0, 0);
    chk("asr", int'(out), 4'b1100);

    // Burst ROL x4 on 1011
    step(1'b1, 4'b1011, 0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 0, 3, 1'b0, 1'b0, 1'b1, 4);
    chk("rol_start_out", int'(out), 4'b1011);
    chk("rol_start_busy", int'(busy), 1);
    idle(0); chk("rol1", int'(out), 4'b0111);
    idle(0); chk("rol2", int'(out), 4'b1110);
    idle(0); chk("rol3", int'(out), 4'b1101);
    idle(0); chk("rol4", int'(out), 4'b1011);
    chk("rol_done", int'(done), 1);
    chk("rol_busy_end", int'(busy), 0);
    idle(0);
    chk("rol_done_pulse", int'(done), 0);

    // Burst ASR x2, live mode changes ignored
    step(1'b1, 4'b1010, 0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 0, 5, 1'b0, 1'b0, 1'b1, 2);
    idle(0);
    idle(1);
    chk("asr_burst", int'(out), 4'b1110);
    chk("asr_done", int'(done), 1);

    // count=0 and clamped count=7
    step(1'b0, 0, 3, 1'b0, 1'b0, 1'b1, 0);
    chk("cnt0_done", int'(done), 1);
    chk("cnt0_out", int'(out), 4'b1110);
    step(1'b1, 4'b0110, 0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 0, 1, 1'b1, 1'b0, 1'b1, 7);
    repeat (4) step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
    chk("clamp_out", int'(out), 4'b1111);
    chk("clamp_done", int'(done), 1);

    // Load aborts ROR burst on 2nd RUN cycle
    step(1'b1, 4'b1011, 0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 0, 4, 1'b0, 1'b0, 1'b1, 4);
    idle(0);
    step(1'b1, 4'b0101, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("abort_out", int'(out), 4'b0101);
    chk("abort_busy", int'(busy), 0);
    idle(0);
    chk("abort_nodone", int'(done), 0);

    // Reset mid-burst
    step(1'b0, 0, 3, 1'b0, 1'b0, 1'b1, 4);
    idle(0);
    async_reset();
    idle(0);
    chk("rst_burst_done", int'(done), 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 12) == 0, int'($urandom % 16),
           int'($urandom % 8), 1'($urandom), 1'($urandom),
           ($urandom % 4) == 0, int'($urandom % 8));
      chk("excl", int'(busy && done), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
